// File: rtl/lsu_issue_unit.sv
// lsu_issue_unit: in-order load/store issue queue with store credits and CDB load broadcast.
// Ports: clk/reset (async, active-high); rs_* request handshake from the reservation station;
// load_en/store_en/mm_addr/store_data to the memory buffer; store_commit returns a store credit;
// load_data is the memory result, broadcast on cdb_valid/cdb_tag/cdb_data the cycle after a load
// issues; credits = free store slots; fault pulses when an out-of-range entry is dropped.
// Optional feature: define LSU_BOUNDS_CHECK_EN to fault entries whose base+offset leaves 0..4095.
module lsu_issue_unit #(
  parameter int FIFO_DEPTH  = 4,
  parameter int LSQ_CREDITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rs_valid,
  output logic        rs_ready,
  input  logic        rs_is_store,
  input  logic [3:0]  rs_tag,
  input  logic [11:0] rs_base,
  input  logic [5:0]  rs_offset,
  input  logic [15:0] rs_store_data,
  output logic        load_en,
  output logic        store_en,
  output logic [11:0] mm_addr,
  output logic [15:0] store_data,
  input  logic        store_commit,
  input  logic [15:0] load_data,
  output logic        cdb_valid,
  output logic [3:0]  cdb_tag,
  output logic [15:0] cdb_data,
  output logic [3:0]  credits,
  output logic        fault
);
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic        is_store;
    logic        flt;
    logic [3:0]  tag;
    logic [11:0] addr;
    logic [15:0] data;
  } entry_t;
  entry_t          mem_q [FIFO_DEPTH];
  entry_t          head, new_entry;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      credits_q, credits_d;
  logic            load_en_q, load_en_d, store_en_q, store_en_d;
  logic            fault_q, fault_d, cdb_valid_q, cdb_valid_d;
  logic [11:0]     mm_addr_q, mm_addr_d;
  logic [15:0]     store_data_q, store_data_d;
  logic [3:0]      cdb_tag_q, cdb_tag_d, issue_tag_q, issue_tag_d;
  logic [12:0]     sum;
  logic            enq, deq, ld_issue, st_issue;
  // A 13-bit sum of the zero-extended base and sign-extended offset has bit 12 set exactly when
  // the true address is below 0 or above 4095, given the limited offset range.
  always_comb begin
    sum       = {1'b0, rs_base} + {{7{rs_offset[5]}}, rs_offset};
    new_entry = '{is_store: rs_is_store, flt: BOUNDS && sum[12], tag: rs_tag,
                  addr: sum[11:0], data: rs_store_data};
    head      = mem_q[rd_ptr_q];
    rs_ready  = count_q != CW'(FIFO_DEPTH);
    enq       = rs_valid && rs_ready;
    // A head store without credits stalls the whole queue; faulting entries drop regardless.
    deq       = (count_q != '0) && (!head.is_store || head.flt || credits_q != '0);
    ld_issue  = deq && !head.is_store && !head.flt;
    st_issue  = deq && head.is_store && !head.flt;
    wr_ptr_d  = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(enq) - CW'(deq);
    credits_d = (st_issue && !store_commit) ? credits_q - 4'd1 :
                (store_commit && !st_issue && credits_q != 4'(LSQ_CREDITS)) ? credits_q + 4'd1 :
                credits_q;
    load_en_d    = ld_issue;
    store_en_d   = st_issue;
    fault_d      = deq && head.flt;
    mm_addr_d    = (ld_issue || st_issue) ? head.addr : mm_addr_q;
    store_data_d = (ld_issue || st_issue) ? head.data : store_data_q;
    issue_tag_d  = ld_issue ? head.tag : issue_tag_q;
    cdb_valid_d  = load_en_q;
    cdb_tag_d    = load_en_q ? issue_tag_q : cdb_tag_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      credits_q    <= 4'(LSQ_CREDITS);
      load_en_q    <= 1'b0;
      store_en_q   <= 1'b0;
      fault_q      <= 1'b0;
      mm_addr_q    <= '0;
      store_data_q <= '0;
      issue_tag_q  <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      credits_q    <= credits_d;
      load_en_q    <= load_en_d;
      store_en_q   <= store_en_d;
      fault_q      <= fault_d;
      mm_addr_q    <= mm_addr_d;
      store_data_q <= store_data_d;
      issue_tag_q  <= issue_tag_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
    end
  end
  // Entry storage needs no reset: validity is tracked entirely by the occupancy counter.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= new_entry;
  end
  assign load_en    = load_en_q;
  assign store_en   = store_en_q;
  assign mm_addr    = mm_addr_q;
  assign store_data = store_data_q;
  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_data   = cdb_valid_q ? load_data : 16'h0000;
  assign credits    = credits_q;
  assign fault      = fault_q;
endmodule

// File: tb/tb_lsu_issue_unit.sv
// tb_lsu_issue_unit: directed and random checks of lsu_issue_unit against a queue-based model.
module tb_lsu_issue_unit;
  localparam int DEPTH = 4;
  localparam int LSQ   = 8;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset;
  logic        rs_valid, rs_ready, rs_is_store, load_en, store_en, store_commit;
  logic        cdb_valid, fault;
  logic [3:0]  rs_tag, cdb_tag, credits;
  logic [11:0] rs_base, mm_addr;
  logic [5:0]  rs_offset;
  logic [15:0] rs_store_data, store_data, load_data, cdb_data;
  int          errors = 0;
  int          checks = 0;
  typedef struct {
    bit        st;
    bit        flt;
    bit [3:0]  tag;
    bit [11:0] addr;
    bit [15:0] data;
  } req_t;
  req_t        q[$];
  int          cr;
  bit          e_ld, e_st, e_flt, e_cv;
  bit [11:0]   e_addr;
  bit [15:0]   e_sd;
  bit [3:0]    e_ctag, last_tag;
  int          pulses, acc;
  bit          will;

  lsu_issue_unit #(.FIFO_DEPTH(DEPTH), .LSQ_CREDITS(LSQ)) dut (
    .clk(clk), .reset(reset), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .rs_is_store(rs_is_store), .rs_tag(rs_tag), .rs_base(rs_base), .rs_offset(rs_offset),
    .rs_store_data(rs_store_data), .load_en(load_en), .store_en(store_en), .mm_addr(mm_addr),
    .store_data(store_data), .store_commit(store_commit), .load_data(load_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .credits(credits),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cr = LSQ;
    {e_ld, e_st, e_flt, e_cv} = '0;
    e_addr = '0; e_sd = '0; e_ctag = '0; last_tag = '0;
  endtask

  // One clock edge of the intended behaviour, driven from the inputs present at that edge.
  task automatic model_edge();
    bit   accept = rs_valid && (q.size() < DEPTH);
    bit   ld = 0, st = 0, fl = 0;
    int   s;
    req_t h, n;
    e_cv = e_ld;
    if (e_ld) e_ctag = last_tag;
    if (q.size() > 0 && (q[0].flt || !q[0].st || cr > 0)) begin
      h = q.pop_front();
      if (h.flt) fl = 1;
      else begin
        ld = !h.st; st = h.st; e_addr = h.addr; e_sd = h.data;
        if (ld) last_tag = h.tag;
      end
    end
    e_ld = ld; e_st = st; e_flt = fl;
    cr = cr - int'(st) + int'(store_commit);
    if (cr > LSQ) cr = LSQ;
    if (accept) begin
      s = int'(rs_base) + int'($signed(rs_offset));
      n.st = rs_is_store; n.tag = rs_tag; n.data = rs_store_data;
      n.flt = BOUNDS && (s < 0 || s > 4095);
      n.addr = s[11:0];
      q.push_back(n);
    end
  endtask

  task automatic check_all();
    check("m_load_en", load_en, e_ld);
    check("m_store_en", store_en, e_st);
    check("m_fault", fault, e_flt);
    check("m_mm_addr", mm_addr, e_addr);
    check("m_store_data", store_data, e_sd);
    check("m_cdb_valid", cdb_valid, e_cv);
    check("m_cdb_data", cdb_data, e_cv ? load_data : 16'h0);
    if (e_cv) check("m_cdb_tag", cdb_tag, e_ctag);
    check("m_credits", credits, cr);
    check("m_rs_ready", rs_ready, q.size() < DEPTH);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit st, input bit [3:0] tag, input bit [11:0] base,
                       input bit [5:0] off, input bit [15:0] data);
    rs_valid = 1; rs_is_store = st; rs_tag = tag; rs_base = base; rs_offset = off;
    rs_store_data = data;
  endtask

  task automatic do_reset();
    rs_valid = 0; store_commit = 0; reset = 1;
    step(); step();
    reset = 0;
  endtask

  initial begin
    {rs_valid, rs_is_store, store_commit} = '0;
    rs_tag = '0; rs_base = '0; rs_offset = '0; rs_store_data = '0; load_data = 16'hBEEF;
    reset = 1;
    model_reset();
    step(); step();
    check("rst_credits", credits, 4'd8);
    check("rst_ready", rs_ready, 1'b1);
    check("rst_mm_addr", mm_addr, 12'h000);
    check("rst_cdb_tag", cdb_tag, 4'h0);
    reset = 0;
    // load with negative offset, then its CDB broadcast
    drive(0, 4'd5, 12'h010, 6'h3E, 16'h1234);
    step();
    rs_valid = 0;
    step();
    check("ld_en", load_en, 1'b1);
    check("ld_addr", mm_addr, 12'h00E);
    step();
    check("cdb_valid", cdb_valid, 1'b1);
    check("cdb_tag", cdb_tag, 4'd5);
    check("cdb_data", cdb_data, 16'hBEEF);
    step();
    check("cdb_single", cdb_valid, 1'b0);
    check("cdb_data_zero", cdb_data, 16'h0000);
    // nine stores without commits: eight issue, the ninth waits for a credit
    pulses = 0; acc = 0;
    for (int i = 0; i < 30; i++) begin
      if (acc < 9) drive(1, 4'(i), 12'(100 + i), 6'h00, 16'($urandom));
      else rs_valid = 0;
      will = rs_valid && (q.size() < DEPTH);
      step();
      if (will) acc++;
      pulses += int'(store_en);
    end
    rs_valid = 0;
    check("st_pulses", pulses, 8);
    check("st_credits0", credits, 4'd0);
    check("st_held", store_en, 1'b0);
    store_commit = 1;
    step();
    store_commit = 0;
    check("commit_credit", credits, 4'd1);
    step();
    check("st9_issue", store_en, 1'b1);
    check("st9_credits", credits, 4'd0);
    // blocked store stalls a younger load
    drive(1, 4'd3, 12'h200, 6'h01, 16'hAAAA);
    step();
    drive(0, 4'd7, 12'h300, 6'h02, 16'h0);
    step();
    rs_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ld_blocked", load_en, 1'b0);
    end
    store_commit = 1;
    step();
    store_commit = 0;
    check("blk_st_wait", store_en, 1'b0);
    step();
    check("blk_st_issue", store_en, 1'b1);
    check("blk_st_addr", mm_addr, 12'h201);
    check("blk_ld_wait", load_en, 1'b0);
    step();
    check("blk_ld_issue", load_en, 1'b1);
    check("blk_ld_addr", mm_addr, 12'h302);
    // fill with no issue possible, then commit and issue together
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'(i), 12'(i), 6'h00, 16'(i));
      step();
    end
    rs_valid = 0;
    check("full_ready", rs_ready, 1'b0);
    store_commit = 1;
    step();
    check("full_cr1", credits, 4'd1);
    step();
    store_commit = 0;
    check("both_credits", credits, 4'd1);
    check("both_st_en", store_en, 1'b1);
    check("both_ready", rs_ready, 1'b1);
    // address past the top of memory
    do_reset();
    drive(0, 4'd9, 12'hFFF, 6'h01, 16'h0);
    step();
    rs_valid = 0;
    step();
`ifdef LSU_BOUNDS_CHECK_EN
    check("oob_fault", fault, 1'b1);
    check("oob_no_ld", load_en, 1'b0);
`else
    check("oob_fault0", fault, 1'b0);
    check("oob_ld", load_en, 1'b1);
`endif
    check("oob_addr", mm_addr, 12'h000);
    check("oob_no_st", store_en, 1'b0);
    step();
    check("oob_pulse_end", fault, 1'b0);
    // reset right after a load issue kills the pending broadcast
    do_reset();
    drive(0, 4'd6, 12'h040, 6'h00, 16'h0);
    step();
    rs_valid = 0;
    step();
    check("pre_rst_ld", load_en, 1'b1);
    reset = 1;
    #1;
    check("async_ld_clr", load_en, 1'b0);
    check("async_cdb_clr", cdb_valid, 1'b0);
    step(); step();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_cdb", cdb_valid, 1'b0);
    end
    check("post_rst_cr", credits, 4'd8);
    check("post_rst_ready", rs_ready, 1'b1);
    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      rs_valid = 1'($urandom_range(0, 1));
      rs_is_store = 1'($urandom_range(0, 1));
      rs_tag = 4'($urandom);
      rs_base = ($urandom_range(0, 3) == 0) ? 12'(4064 + $urandom_range(0, 31)) : 12'($urandom);
      rs_offset = 6'($urandom);
      rs_store_data = 16'($urandom);
      store_commit = ($urandom_range(0, 2) == 0);
      load_data = 16'($urandom);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
